gate_stim_checker: RTL
======================

GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
- REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
- REQ-002 Parameter: SETTLE_CYCLES, default 2, number of cycles y is allowed to settle after a/b change (legal 0..15).
- REQ-003 clk  input  1  rising-edge clock for all state.
- REQ-004 rst  input  1  synchronous active-high reset.
- REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
- REQ-006 truth_table  input  4  expected y; bit i is the expected value for {a,b}=i; captured at start.
- REQ-007 a  output  1  registered stimulus to gate input a (MSB of vector).
- REQ-008 b  output  1  registered stimulus to gate input b (LSB of vector).
- REQ-009 y  input  1  gate response under test.
- REQ-010 busy  output  1  high from the cycle after start is accepted until done.
- REQ-011 done  output  1  one-cycle pulse when the sweep completes.
- REQ-012 pass  output  1  high when the last sweep had zero mismatches; held until the next accepted start.
- REQ-013 err_count  output  3  mismatch count of the current or last sweep (0..4).
- REQ-014 fail_vec  output  2  first failing {a,b} (present only with FIRST_FAIL_CAPTURE_EN).

Function
- REQ-015 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
- REQ-016 In IDLE with start=1: latch truth_table, clear err_count and pass, set vector index to 0, drive {a,b}=00, assert busy, go to SETTLE.
- REQ-017 SETTLE SHALL last SETTLE_CYCLES cycles, counted by a settle counter; with SETTLE_CYCLES=0 it SHALL last 0 cycles (direct to CHECK).
- REQ-018 CHECK SHALL last one cycle and compare y against the latched truth_table[index]; mismatch increments err_count (saturating at 4).
- REQ-019 After CHECK with index<3: increment index, drive {a,b}=index+1 on the same edge, return to SETTLE.
- REQ-020 After CHECK with index=3: go to DONE; pass = (final err_count==0).
- REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then go to IDLE.
- REQ-022 Each vector occupies SETTLE_CYCLES+1 cycles, so done SHALL assert exactly 4*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.
- REQ-023 start while not in IDLE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new sweep.
- REQ-024 a and b SHALL hold their last value in DONE and IDLE.
- REQ-025 truth_table changes during a sweep SHALL have no effect.

Reset
- REQ-026 On rst=1 at a clock edge: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, counters=0.
- REQ-027 Reset mid-sweep SHALL abort without a done pulse; rst SHALL take priority over start in the same cycle.

Configuration
- REQ-028 Macro GATE_STIM_FIRST_FAIL_CAPTURE_EN: when defined, fail_vec SHALL capture {a,b} of the first mismatch of a sweep and hold it until the next accepted start.
- REQ-029 When GATE_STIM_FIRST_FAIL_CAPTURE_EN is undefined, the fail_vec port and its register SHALL be absent; all other behaviour is unchanged.

Structure
- REQ-030 A shared package gate_stim_pkg SHALL hold the FSM state encoding, the vector count constant (4) and the standard truth tables AND=4'b1000, OR=4'b1110, XOR=4'b0110, NAND=4'b0111.
- REQ-031 The settle counter SHALL be one sub-module, settle_timer (load, count-down, zero flag).

Verification
- REQ-032 The bench SHALL instantiate this block with the team's and_gate as the DUT, SETTLE_CYCLES=2, truth_table=AND, start pulse -> done at cycle 13, pass=1, err_count=0, a/b sequence 00,01,10,11.
- REQ-033 Same DUT, truth_table=OR -> err_count=2, pass=0, fail_vec=2'b01 (macro defined).
- REQ-034 SETTLE_CYCLES=0, truth_table=AND -> done 5 cycles after start, pass=1.
- REQ-035 rst asserted during the vector 10 check -> next cycle busy=0, a=b=0, err_count=0, and no done pulse.
- REQ-036 start held high continuously -> back-to-back sweeps with exactly one done pulse per sweep and no start accepted while busy.

Source files
------------

// File: rtl/gate_stim_pkg.sv
// Shared definitions for the gate stimulus checker: FSM encoding, vector count
// and standard two-input truth tables (bit i = expected y for {a,b}=i).
package gate_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Settle down-counter: load a cycle count, decrement while enabled, flag zero.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/gate_stim_checker.sv
// Sweeps {a,b} through 00..11, waits SETTLE_CYCLES per vector, checks y against a latched truth table.
// Define GATE_STIM_FIRST_FAIL_CAPTURE_EN to add fail_vec (first mismatching vector of a sweep).
//
// state  | meaning
// IDLE   | waiting for start; a/b and results hold
// SETTLE | y settling after a/b changed
// CHECK  | compare y with latched truth-table bit
// DONE   | one-cycle done pulse, results final
module gate_stim_checker
    import gate_stim_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] truth_table,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
`ifdef GATE_STIM_FIRST_FAIL_CAPTURE_EN
    output logic [1:0] fail_vec,
`endif
    output logic [2:0] err_count
);

    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);
    // Timer exits SETTLE on reaching zero, so it is loaded one short of the settle length.
    localparam logic [3:0] SETTLE_LOAD = SKIP_SETTLE ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] vec;
    logic [3:0] tt_q;
    logic [2:0] err_nxt;
    logic       mismatch;
    logic       last_vec;
    logic       timer_load;
    logic       timer_en;
    logic       timer_zero;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    assign mismatch = (y != tt_q[vec]);
    assign last_vec = (vec == 2'(NUM_VECTORS - 1));
    assign err_nxt  = (mismatch && (err_count != 3'(NUM_VECTORS))) ? err_count + 3'd1 : err_count;

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    timer_load = 1'b1;
                    state_nxt  = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_nxt = ST_CHECK;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_CHECK: begin
                if (last_vec) begin
                    state_nxt = ST_DONE;
                end else begin
                    timer_load = 1'b1;
                    state_nxt  = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec       <= 2'b00;
            tt_q      <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
`ifdef GATE_STIM_FIRST_FAIL_CAPTURE_EN
            fail_vec  <= 2'b00;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tt_q      <= truth_table;
                        err_count <= 3'd0;
                        pass      <= 1'b0;
                        vec       <= 2'b00;
`ifdef GATE_STIM_FIRST_FAIL_CAPTURE_EN
                        fail_vec  <= 2'b00;
`endif
                    end
                end
                ST_CHECK: begin
                    err_count <= err_nxt;
`ifdef GATE_STIM_FIRST_FAIL_CAPTURE_EN
                    if (mismatch && (err_count == 3'd0)) begin
                        fail_vec <= vec;
                    end
`endif
                    if (last_vec) begin
                        pass <= (err_nxt == 3'd0);
                    end else begin
                        vec <= vec + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The vector register is the stimulus itself, so a/b hold through DONE and IDLE.
    assign a    = vec[1];
    assign b    = vec[0];
    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

endmodule
